// File: rtl/nkmd_mig_pkg.sv
// rtl/nkmd_mig_pkg.sv - shared constants and types for the MIG port arbiter
package nkmd_mig_pkg;

  localparam logic [2:0] MIG_INSTR_WR = 3'b000;
  localparam logic [2:0] MIG_INSTR_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_WR_CMD  = 2'd2,
    ST_RD_CMD  = 2'd3
  } state_t;

  // One entry per outstanding read: which client owns it and its burst length minus 1
  typedef struct packed {
    logic       client;
    logic [5:0] bl;
  } tag_t;

endpackage

// File: rtl/nkmd_mig_tag_fifo.sv
// rtl/nkmd_mig_tag_fifo.sv - in-order tracker of outstanding read commands
module nkmd_mig_tag_fifo
  import nkmd_mig_pkg::*;
#(
  parameter int TAG_DEPTH_LOG2 = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tag_t push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output tag_t head
);
  localparam int DEPTH = 2 ** TAG_DEPTH_LOG2;

  tag_t                      mem [DEPTH];
  logic [TAG_DEPTH_LOG2-1:0] wr_ptr;
  logic [TAG_DEPTH_LOG2-1:0] rd_ptr;
  logic [TAG_DEPTH_LOG2:0]   count;
  logic                      do_push;
  logic                      do_pop;

  // A pop frees the slot in the same cycle, so push-while-full is honoured alongside it
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (TAG_DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nkmd_mig_arbiter.sv
// rtl/nkmd_mig_arbiter.sv - round-robin sharing of one MIG user port between two DMA clients
module nkmd_mig_arbiter
  import nkmd_mig_pkg::*;
#(
  parameter int TAG_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_cmd_valid,
  output logic        c0_cmd_ready,
  input  logic        c0_cmd_write,
  input  logic [29:0] c0_cmd_byte_addr,
  input  logic [5:0]  c0_cmd_bl,
  output logic        c0_wr_pop,
  input  logic [31:0] c0_wr_data,
  output logic        c0_rd_valid,
  output logic [31:0] c0_rd_data,
  input  logic        c1_cmd_valid,
  output logic        c1_cmd_ready,
  input  logic        c1_cmd_write,
  input  logic [29:0] c1_cmd_byte_addr,
  input  logic [5:0]  c1_cmd_bl,
  output logic        c1_wr_pop,
  input  logic [31:0] c1_wr_data,
  output logic        c1_rd_valid,
  output logic [31:0] c1_rd_data,
  output logic        mig_cmd_clk,
  output logic        mig_cmd_en,
  output logic [2:0]  mig_cmd_instr,
  output logic [5:0]  mig_cmd_bl,
  output logic [29:0] mig_cmd_byte_addr,
  input  logic        mig_cmd_full,
  output logic        mig_wr_clk,
  output logic        mig_wr_en,
  output logic [3:0]  mig_wr_mask,
  output logic [31:0] mig_wr_data,
  input  logic        mig_wr_full,
  output logic        mig_rd_clk,
  output logic        mig_rd_en,
  input  logic [31:0] mig_rd_data,
  input  logic        mig_rd_empty,
  input  logic        mig_rd_overflow,
  input  logic        mig_rd_error,
  output logic        err
);
  state_t      state;
  logic        last_grant;
  logic        lat_client;
  logic        lat_write;
  logic [29:0] lat_addr;
  logic [5:0]  lat_bl;
  logic [5:0]  burst_cnt;
  logic [5:0]  rd_cnt;
  logic [1:0]  ready_q;
  logic        el0;
  logic        el1;
  logic        pick;
  logic        tag_push;
  logic        tag_pop;
  logic        tag_full;
  logic        tag_empty;
  tag_t        tag_head;

  assign mig_cmd_clk = clk;
  assign mig_wr_clk  = clk;
  assign mig_rd_clk  = clk;
  assign mig_wr_mask = 4'b0000;

  // A read needs a free tag slot; writes never do
  assign el0  = c0_cmd_valid && (c0_cmd_write || !tag_full);
  assign el1  = c1_cmd_valid && (c1_cmd_write || !tag_full);
  assign pick = (el0 && el1) ? !last_grant : el1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      lat_client <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_bl     <= '0;
      burst_cnt  <= '0;
      ready_q    <= 2'b00;
    end else begin
      ready_q <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (el0 || el1) begin
            lat_client <= pick;
            lat_write  <= pick ? c1_cmd_write : c0_cmd_write;
            lat_addr   <= pick ? c1_cmd_byte_addr : c0_cmd_byte_addr;
            lat_bl     <= pick ? c1_cmd_bl : c0_cmd_bl;
            burst_cnt  <= pick ? c1_cmd_bl : c0_cmd_bl;
            last_grant <= pick;
            ready_q    <= pick ? 2'b10 : 2'b01;
            state      <= (pick ? c1_cmd_write : c0_cmd_write) ? ST_WR_DATA : ST_RD_CMD;
          end
        end
        ST_WR_DATA: begin
          if (!mig_wr_full) begin
            if (burst_cnt == 6'd0) state <= ST_WR_CMD;
            else                   burst_cnt <= burst_cnt - 6'd1;
          end
        end
        ST_WR_CMD, ST_RD_CMD: begin
          if (!mig_cmd_full) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign c0_cmd_ready = ready_q[0];
  assign c1_cmd_ready = ready_q[1];

  assign mig_wr_en   = (state == ST_WR_DATA) && !mig_wr_full;
  assign mig_wr_data = lat_client ? c1_wr_data : c0_wr_data;
  assign c0_wr_pop   = mig_wr_en && !lat_client;
  assign c1_wr_pop   = mig_wr_en && lat_client;

  assign mig_cmd_en        = ((state == ST_WR_CMD) || (state == ST_RD_CMD)) && !mig_cmd_full;
  assign mig_cmd_instr     = lat_write ? MIG_INSTR_WR : MIG_INSTR_RD;
  assign mig_cmd_bl        = lat_bl;
  assign mig_cmd_byte_addr = lat_addr;
  assign tag_push          = (state == ST_RD_CMD) && !mig_cmd_full;

  nkmd_mig_tag_fifo #(
    .TAG_DEPTH_LOG2(TAG_DEPTH_LOG2)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data ({lat_client, lat_bl}),
    .pop       (tag_pop),
    .full      (tag_full),
    .empty     (tag_empty),
    .head      (tag_head)
  );

  // Return path runs independently of the grant FSM; data is steered by the head tag
  assign mig_rd_en   = !mig_rd_empty && !tag_empty;
  assign tag_pop     = mig_rd_en && (rd_cnt == tag_head.bl);
  assign c0_rd_valid = mig_rd_en && !tag_head.client;
  assign c1_rd_valid = mig_rd_en && tag_head.client;
  assign c0_rd_data  = mig_rd_data;
  assign c1_rd_data  = mig_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (mig_rd_en) rd_cnt <= tag_pop ? 6'd0 : rd_cnt + 6'd1;
      if (mig_rd_overflow || mig_rd_error || (!mig_rd_empty && tag_empty)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nkmd_mig_arbiter.sv
// tb/tb_nkmd_mig_arbiter.sv - randomized self-checking bench with a transaction-level MIG/client model
module tb_nkmd_mig_arbiter;

  typedef struct {
    bit          client;
    bit          write;
    logic [29:0] addr;
    logic [5:0]  bl;
    logic [31:0] base;
  } cmd_t;

  typedef struct {
    bit          client;
    logic [31:0] data;
  } ret_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_write;
  logic [29:0] cmd_addr [2];
  logic [5:0]  cmd_bl [2];
  logic [31:0] wdata [2];
  wire  [1:0]  cmd_ready;
  wire  [1:0]  wr_pop;
  wire  [1:0]  rd_valid;
  wire  [31:0] rd_data0, rd_data1;
  wire         mig_cmd_clk, mig_cmd_en, mig_wr_clk, mig_wr_en, mig_rd_clk, mig_rd_en, err;
  wire  [2:0]  mig_cmd_instr;
  wire  [5:0]  mig_cmd_bl;
  wire  [29:0] mig_cmd_byte_addr;
  wire  [3:0]  mig_wr_mask;
  wire  [31:0] mig_wr_data;
  logic        mig_cmd_full, mig_wr_full, mig_rd_empty, mig_rd_overflow, mig_rd_error;
  logic [31:0] mig_rd_data;

  nkmd_mig_arbiter #(.TAG_DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst),
    .c0_cmd_valid(cmd_valid[0]), .c0_cmd_ready(cmd_ready[0]), .c0_cmd_write(cmd_write[0]),
    .c0_cmd_byte_addr(cmd_addr[0]), .c0_cmd_bl(cmd_bl[0]), .c0_wr_pop(wr_pop[0]),
    .c0_wr_data(wdata[0]), .c0_rd_valid(rd_valid[0]), .c0_rd_data(rd_data0),
    .c1_cmd_valid(cmd_valid[1]), .c1_cmd_ready(cmd_ready[1]), .c1_cmd_write(cmd_write[1]),
    .c1_cmd_byte_addr(cmd_addr[1]), .c1_cmd_bl(cmd_bl[1]), .c1_wr_pop(wr_pop[1]),
    .c1_wr_data(wdata[1]), .c1_rd_valid(rd_valid[1]), .c1_rd_data(rd_data1),
    .mig_cmd_clk(mig_cmd_clk), .mig_cmd_en(mig_cmd_en), .mig_cmd_instr(mig_cmd_instr),
    .mig_cmd_bl(mig_cmd_bl), .mig_cmd_byte_addr(mig_cmd_byte_addr), .mig_cmd_full(mig_cmd_full),
    .mig_wr_clk(mig_wr_clk), .mig_wr_en(mig_wr_en), .mig_wr_mask(mig_wr_mask),
    .mig_wr_data(mig_wr_data), .mig_wr_full(mig_wr_full),
    .mig_rd_clk(mig_rd_clk), .mig_rd_en(mig_rd_en), .mig_rd_data(mig_rd_data),
    .mig_rd_empty(mig_rd_empty), .mig_rd_overflow(mig_rd_overflow), .mig_rd_error(mig_rd_error),
    .err(err)
  );

  always #5 clk = ~clk;

  cmd_t        cq [2][$];
  cmd_t        gq [$];
  ret_t        ret [$];
  cmd_t        bcur [2];
  bit          in_burst [2];
  int          widx [2];
  int          glog [$];
  logic [31:0] rx [2][$];
  int          wcnt, n_wr, n_cmd, full_left, stall_at;
  bit          exp_err, rnd_full, rnd_stall, rand_data, hold_ret, force_rd, err_pulse;
  logic [31:0] ret_ctr;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic cmd_t mk(bit c, bit w, logic [29:0] a, logic [5:0] b, logic [31:0] base);
    cmd_t x;
    x.client = c; x.write = w; x.addr = a; x.bl = b; x.base = base;
    return x;
  endfunction

  task automatic drive();
    for (int c = 0; c < 2; c++) begin
      cmd_valid[c] = (cq[c].size() != 0);
      if (cq[c].size() != 0) begin
        cmd_write[c] = cq[c][0].write;
        cmd_addr[c]  = cq[c][0].addr;
        cmd_bl[c]    = cq[c][0].bl;
      end else begin
        cmd_write[c] = 1'b0;
        cmd_addr[c]  = '0;
        cmd_bl[c]    = '0;
      end
      if (in_burst[c])             wdata[c] = bcur[c].base + 32'(widx[c]);
      else if (cq[c].size() != 0)  wdata[c] = cq[c][0].base;
      else                         wdata[c] = '0;
    end
    mig_cmd_full = rnd_full && ($urandom_range(3) == 0);
    mig_wr_full  = (full_left > 0) || (rnd_full && ($urandom_range(3) == 0));
    if (full_left > 0) full_left--;
    mig_rd_empty = force_rd ? 1'b0 :
                   (hold_ret || ret.size() == 0 || (rnd_stall && $urandom_range(2) == 0));
    mig_rd_data  = (ret.size() != 0) ? ret[0].data : 32'hDEAD0000;
    mig_rd_error    = err_pulse;
    mig_rd_overflow = 1'b0;
  endtask

  // Outputs observed here describe the transfer committed at the next rising edge
  task automatic sample();
    ret_t r;
    cmd_t g;
    bit   exp_rd;
    check("err", 32'(err), 32'(exp_err));
    exp_rd = !mig_rd_empty && ret.size() != 0;
    if (mig_rd_error || mig_rd_overflow || (!mig_rd_empty && ret.size() == 0)) exp_err = 1'b1;
    check("rd_en", 32'(mig_rd_en), 32'(exp_rd));
    if (exp_rd) begin
      r = ret.pop_front();
      check("rd_valid", 32'(rd_valid), r.client ? 32'd2 : 32'd1);
      check("rd_data", r.client ? rd_data1 : rd_data0, r.data);
      rx[r.client].push_back(r.data);
    end else if (rd_valid != 2'b00) check("rd_valid_idle", 32'(rd_valid), 32'd0);

    if (cmd_ready != 2'b00) check("ready_onehot", 32'($countones(cmd_ready)), 32'd1);
    for (int c = 0; c < 2; c++) begin
      if (cmd_ready[c]) begin
        if (cq[c].size() == 0) check("ready_no_req", 32'd1, 32'd0);
        else begin
          g = cq[c].pop_front();
          gq.push_back(g);
          glog.push_back(c);
          if (g.write) begin in_burst[c] = 1'b1; bcur[c] = g; widx[c] = 0; end
        end
      end
    end

    if (mig_wr_full) check("wr_while_full", 32'({mig_wr_en, wr_pop}), 32'd0);
    if (mig_wr_en) begin
      n_wr++;
      if (gq.size() == 0 || !gq[0].write) check("wr_unexpected", 32'd1, 32'd0);
      else begin
        check("wr_data", mig_wr_data, gq[0].base + 32'(wcnt));
        check("wr_pop", 32'(wr_pop), gq[0].client ? 32'd2 : 32'd1);
        wcnt++;
        if (wcnt == stall_at) begin full_left = 3; stall_at = -1; end
      end
    end else if (wr_pop != 2'b00) check("wr_pop_idle", 32'(wr_pop), 32'd0);
    for (int c = 0; c < 2; c++) begin
      if (wr_pop[c] && in_burst[c]) begin
        widx[c]++;
        if (widx[c] > int'(bcur[c].bl)) begin in_burst[c] = 1'b0; widx[c] = 0; end
      end
    end

    if (mig_cmd_en) begin
      n_cmd++;
      check("cmd_while_full", 32'(mig_cmd_full), 32'd0);
      if (gq.size() == 0) check("cmd_unexpected", 32'd1, 32'd0);
      else begin
        g = gq.pop_front();
        check("cmd_instr", 32'(mig_cmd_instr), g.write ? 32'd0 : 32'd1);
        check("cmd_bl", 32'(mig_cmd_bl), 32'(g.bl));
        check("cmd_addr", 32'(mig_cmd_byte_addr), 32'(g.addr));
        if (g.write) begin
          check("wr_words", 32'(wcnt), 32'(g.bl) + 32'd1);
          wcnt = 0;
        end else begin
          for (int i = 0; i <= int'(g.bl); i++) begin
            r.client = g.client;
            r.data   = rand_data ? $urandom() : ret_ctr;
            if (!rand_data) ret_ctr++;
            ret.push_back(r);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    sample();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((cq[0].size() != 0 || cq[1].size() != 0 || gq.size() != 0 || ret.size() != 0 ||
            in_burst[0] || in_burst[1]) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cq[0].delete(); cq[1].delete(); gq.delete(); ret.delete();
    in_burst[0] = 1'b0; in_burst[1] = 1'b0; widx[0] = 0; widx[1] = 0;
    wcnt = 0; exp_err = 1'b0; full_left = 0; stall_at = -1;
    drive();
    #1;
    check("rst_outs", 32'({cmd_ready, wr_pop, rd_valid, mig_cmd_en, mig_wr_en, mig_rd_en, err}), 32'd0);
    check("wr_mask", 32'(mig_wr_mask), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          n0, m0;
    logic [31:0] rv;
    logic [5:0]  b;
    rnd_full = 0; rnd_stall = 0; rand_data = 0; hold_ret = 0; force_rd = 0; err_pulse = 0;
    ret_ctr = 32'h10; n_wr = 0; n_cmd = 0; wcnt = 0; full_left = 0; stall_at = -1; exp_err = 0;
    drive();
    do_reset();

    // single write burst from client 0
    n0 = n_wr; m0 = n_cmd;
    cq[0].push_back(mk(0, 1, 30'h100, 6'd3, 32'hA0));
    run_until_idle(200);
    check("t1_wr_pulses", 32'(n_wr - n0), 32'd4);
    check("t1_cmds", 32'(n_cmd - m0), 32'd1);
    check("t1_grants", 32'(glog.size()), 32'd1);

    // continuous reads from both clients alternate, client 0 first
    do_reset();
    glog.delete();
    for (int i = 0; i < 3; i++) begin
      cq[0].push_back(mk(0, 0, 30'(i * 4), 6'd0, 0));
      cq[1].push_back(mk(1, 0, 30'(32'h200 + i * 4), 6'd0, 0));
    end
    run_until_idle(500);
    for (int i = 0; i < 4; i++)
      check("t3_grant", (i < glog.size()) ? 32'(glog[i]) : 32'hFFFFFFFF, 32'(i % 2));

    // in-order return to the issuing client
    do_reset();
    rx[0].delete(); rx[1].delete(); ret_ctr = 32'h10;
    cq[0].push_back(mk(0, 0, 30'h40, 6'd1, 0));
    cq[1].push_back(mk(1, 0, 30'h80, 6'd2, 0));
    run_until_idle(200);
    check("t4_c0_words", 32'(rx[0].size()), 32'd2);
    check("t4_c1_words", 32'(rx[1].size()), 32'd3);
    for (int i = 0; i < 2; i++)
      check("t4_c0_data", (i < rx[0].size()) ? rx[0][i] : 32'hFFFFFFFF, 32'h10 + 32'(i));
    for (int i = 0; i < 3; i++)
      check("t4_c1_data", (i < rx[1].size()) ? rx[1][i] : 32'hFFFFFFFF, 32'h12 + 32'(i));

    // write FIFO full stall mid burst
    n0 = n_wr;
    stall_at = 3;
    cq[0].push_back(mk(0, 1, 30'h300, 6'd7, 32'h50));
    run_until_idle(200);
    check("t5_wr_pulses", 32'(n_wr - n0), 32'd8);
    check("t5_stall_hit", 32'(stall_at), 32'hFFFFFFFF);

    // tag FIFO full: reads held off, pending write granted instead
    glog.delete();
    hold_ret = 1;
    for (int i = 0; i < 5; i++) cq[0].push_back(mk(0, 0, 30'(32'h400 + i * 16), 6'd3, 0));
    run_cycles(40);
    check("t6_reads_granted", 32'(glog.size()), 32'd4);
    cq[1].push_back(mk(1, 1, 30'h500, 6'd2, 32'hC0));
    run_cycles(30);
    check("t6_write_granted", 32'(glog.size()), 32'd5);
    check("t6_write_client", (glog.size() > 4) ? 32'(glog[4]) : 32'hFFFFFFFF, 32'd1);
    hold_ret = 0;
    run_until_idle(400);
    check("t6_fifth_read", (glog.size() > 5) ? 32'(glog[5]) : 32'hFFFFFFFF, 32'd0);

    // reset in the middle of a write burst
    cq[1].push_back(mk(1, 1, 30'h600, 6'd20, 32'h7000));
    run_cycles(6);
    do_reset();

    // sticky error from rd_error, then from data with no outstanding tag
    err_pulse = 1;
    step();
    err_pulse = 0;
    run_cycles(4);
    check("t7_err_sticky", 32'(err), 32'd1);
    do_reset();
    force_rd = 1;
    step();
    force_rd = 0;
    run_cycles(3);
    check("t7_err_orphan", 32'(err), 32'd1);
    do_reset();

    // randomized mixed traffic with back-pressure everywhere
    rnd_full = 1; rnd_stall = 1; rand_data = 1;
    for (int c = 0; c < 2; c++) begin
      cq[c].push_back(mk(c[0], 1, 30'h1000, 6'd63, $urandom()));
      cq[c].push_back(mk(c[0], 0, 30'h2000, 6'd63, 0));
      cq[c].push_back(mk(c[0], 1, 30'h3000, 6'd0, $urandom()));
      cq[c].push_back(mk(c[0], 0, 30'h4000, 6'd0, 0));
      for (int i = 0; i < 26; i++) begin
        rv = $urandom();
        case ($urandom_range(3))
          0:       b = 6'd0;
          1:       b = 6'd63;
          default: b = 6'($urandom_range(63));
        endcase
        cq[c].push_back(mk(c[0], rv[31], {rv[29:2], 2'b00}, b, $urandom()));
      end
    end
    run_until_idle(40000);
    check("rand_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nkmd_mig_arbiter.md
Name: nkmd_mig_arbiter

Overview:
Shares one MIG user port (cmd, wr and rd FIFOs) between two DMA-style requesters, for example the scratchpad DMA engine and a second bus master.
- Arbitrates commands round-robin.
- Streams write data from the granted client into the MIG write FIFO before issuing the write command.
- Tracks outstanding reads in a tag FIFO so read data returns in order to the client that issued it.
- Sits between the client DMA engines and the MIG hard-block port.

Parameters:
TAG_DEPTH_LOG2, 2, log2 of the number of outstanding read commands tracked (4 entries).

Ports:
clk  in  1  clock, also driven to all mig_*_clk outputs
rst  in  1  reset, asynchronous, active-high
cN_cmd_valid  in  1  client N (N=0,1) command request, held until accepted
cN_cmd_ready  out  1  one-cycle pulse: command accepted
cN_cmd_write  in  1  1=write, 0=read
cN_cmd_byte_addr  in  30  DRAM byte address, 4-byte aligned
cN_cmd_bl  in  6  burst length minus 1 (1..64 words)
cN_wr_pop  out  1  write word consumed this cycle; client advances to next word
cN_wr_data  in  32  current write word, valid whenever the client's write command is granted
cN_rd_valid  out  1  read word valid this cycle; client always accepts
cN_rd_data  out  32  read word
mig_cmd_clk, mig_cmd_en, mig_cmd_instr[2:0], mig_cmd_bl[5:0], mig_cmd_byte_addr[29:0], mig_cmd_full(in)  MIG command port
mig_wr_clk, mig_wr_en, mig_wr_mask[3:0], mig_wr_data[31:0], mig_wr_full(in)  MIG write port
mig_rd_clk, mig_rd_en, mig_rd_data[31:0](in), mig_rd_empty(in), mig_rd_overflow(in), mig_rd_error(in)  MIG read port
err  out  1  sticky: mig_rd_overflow, mig_rd_error, or rd data present with tag FIFO empty

Behaviour:
Reset (asynchronous):
- Cleared: all _en, _ready, _pop, _valid outputs and err.
- State=ST_IDLE; last_grant=1, so client 0 wins the first tie.
- Tag FIFO empty; read word counter=0.

Clocks and constants:
- mig_*_clk = clk.
- mig_wr_mask=4'b0000.
- mig_cmd_bl and mig_cmd_byte_addr come from a latched command register.

Grant FSM:
- ST_IDLE:
  - A client is eligible if valid and either it is a write, or it is a read and the tag FIFO is not full.
  - If both are eligible, grant the one not equal to last_grant.
  - On grant, latch write/addr/bl/client, pulse cN_cmd_ready, set the burst counter to bl, update last_grant.
  - Next state: ST_WR_DATA if write, else ST_RD_CMD.
  - If no client is eligible, stay in ST_IDLE.
- ST_WR_DATA:
  - Each cycle !mig_wr_full: mig_wr_en=1, mig_wr_data=cN_wr_data combinationally, cN_wr_pop=1, decrement the counter.
  - After the word with counter==0 is pushed, go to ST_WR_CMD.
  - mig_wr_full stalls with no pop.
- ST_WR_CMD:
  - When !mig_cmd_full: mig_cmd_en=1, instr=MIG_INSTR_WR, then return to ST_IDLE.
  - Otherwise hold.
- ST_RD_CMD:
  - When !mig_cmd_full: mig_cmd_en=1, instr=MIG_INSTR_RD, push {client, bl} into the tag FIFO, then return to ST_IDLE.
  - Otherwise hold.
- Grant-to-command latency: read, 1 cycle min; write, bl+2 cycles min.

Read return path (runs independently of the grant FSM):
- mig_rd_en = !mig_rd_empty && tag FIFO not empty.
- Per popped word:
  - The client at the head tag gets cN_rd_valid=1 and cN_rd_data=mig_rd_data in the same cycle (combinational; no added latency).
  - The word counter increments.
  - When counter==head.bl, pop the tag and reset the counter to 0.
- A tag push and a tag pop in the same cycle are both honoured; occupancy is unchanged.
- A new read may be granted while earlier reads are still returning.

Boundary conditions:
- bl=0 is a single word; bl=63 is 64 words, and the counters must not overflow 6 bits.
- Tag FIFO full: read requests are ineligible, and a pending write from the other client is granted instead.
- Data in mig_rd_data with the tag FIFO empty: set err, do not pop.
- A cN_cmd_valid drop mid-burst is ignored; the latched command completes.
- Reset mid-burst aborts immediately. Partial MIG FIFO contents are the caller's problem; MIG must also be reset.

Decomposition:
Package nkmd_mig_pkg:
- MIG_INSTR_WR=3'b000, MIG_INSTR_RD=3'b001.
- FSM state encodings.
- Tag entry typedef {client:1, bl:6}.

Sub-module nkmd_mig_tag_fifo:
- Synchronous FIFO, depth 2**TAG_DEPTH_LOG2, 7-bit entries.
- Signals: push, pop, full, empty, head.

Test Plan:
- Reset, then c0 write addr=0x100, bl=3, data 0xA0..0xA3 -> 4 mig_wr_en pulses carrying 0xA0..0xA3, then one mig_cmd_en with instr=000, bl=3, byte_addr=0x100; c0_cmd_ready pulses once; err=0.
- c0 and c1 both valid for reads, continuously -> grants alternate c0,c1,c0 (c0 first after reset); tags record 0,1,0.
- c0 read bl=1 then c1 read bl=2; model returns 5 words 0x10..0x14 -> c0_rd_valid for 0x10 and 0x11, then c1_rd_valid for 0x12..0x14, with no gaps while !mig_rd_empty.
- mig_wr_full held for 3 cycles mid write burst (bl=7) -> no pop or wr_en during the stall; all 8 words delivered exactly once, in order.
- Issue 4 reads with no return data, then c1 write pending -> tag FIFO full; the 5th read (c0) is held off; the c1 write is granted; after 1 burst returns, c0's read is granted.
- mig_rd_error pulse, or rd data with no outstanding tag -> err=1 and stays 1 until rst.
